// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
// Key codes, FSM/frame enums and the row/column to key-code map.
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_kind_e;

    // Rows 0..2 hold 1..9 in reading order; row 3 is "* 0 #".
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_row_scanner.sv
// Column synchronizer, active-low row drive and per-frame key assembly.
// frame_*_c_o are combinational and valid in the last cycle of the row-3 slot.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  col_n_i,
    output logic [3:0]  row_n_o,
    output logic        frame_done_c_o,
    output frame_kind_e frame_kind_c_o,
    output logic [3:0]  frame_code_c_o
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [2:0]    sync1_q, sync2_q;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    drive_q, drive_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;

    logic          slot_end;
    logic [2:0]    hit;
    logic [1:0]    row_hits;
    logic [1:0]    row_col;
    logic [2:0]    sum;
    logic [1:0]    total;
    logic [3:0]    code_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            slot_q     <= '0;
            row_q      <= 2'd0;
            drive_q    <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= KEY_NONE;
        end else begin
            sync1_q    <= col_n_i;
            sync2_q    <= sync1_q;
            slot_q     <= slot_d;
            row_q      <= row_d;
            drive_q    <= drive_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Fold this row's columns into the running frame count (saturating at 2).
    always_comb begin
        hit      = ~sync2_q;
        row_hits = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);
        row_col  = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
        sum      = {1'b0, acc_cnt_q} + {1'b0, row_hits};
        total    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_now = (acc_cnt_q == 2'd0 && row_hits == 2'd1) ? key_map(row_q, row_col)
                                                            : acc_code_q;
        slot_end = (slot_q == SW'(SCAN_DIV - 1));
    end

    always_comb begin
        slot_d     = slot_q + SW'(1);
        row_d      = row_q;
        drive_d    = drive_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (slot_end) begin
            slot_d  = '0;
            row_d   = row_q + 2'd1;
            drive_d = {drive_q[2:0], drive_q[3]};
            if (row_q == 2'd3) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = KEY_NONE;
            end else begin
                acc_cnt_d  = total;
                acc_code_d = code_now;
            end
        end
    end

    always_comb begin
        frame_done_c_o = slot_end && (row_q == 2'd3);
        frame_code_c_o = code_now;
        case (total)
            2'd0:    frame_kind_c_o = NONE;
            2'd1:    frame_kind_c_o = SINGLE;
            default: frame_kind_c_o = MULTI;
        endcase
    end

    assign row_n_o = drive_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: frame-level debounce FSM producing one key_valid pulse
// per accepted press, a held key code and key_down / multi_key levels.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_key,
    output logic [3:0] out_signal,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_key
);

    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic        frame_done_c;
    frame_kind_e frame_kind_c;
    logic [3:0]  frame_code_c;

    kp_state_e   state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic        cnt_full;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_down_q, key_down_d;
    logic        multi_key_q, multi_key_d;

    keypad_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk            (clk),
        .rst_n          (rst_n),
        .col_n_i        (in_key),
        .row_n_o        (out_signal),
        .frame_done_c_o (frame_done_c),
        .frame_kind_c_o (frame_kind_c),
        .frame_code_c_o (frame_code_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= KEY_NONE;
            cnt_q       <= '0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign cnt_inc  = cnt_q + CW'(1);
    assign cnt_full = (cnt_inc >= CW'(DEBOUNCE_FRAMES));

    // Debounce FSM, stepped once per completed scan frame.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        multi_key_d = multi_key_q;

        if (frame_done_c) begin
            multi_key_d = (frame_kind_c == MULTI);
            case (state_q)
                IDLE: begin
                    if (frame_kind_c == SINGLE) begin
                        cand_d = frame_code_c;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            key_code_d  = frame_code_c;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_kind_c == SINGLE && frame_code_c == cand_q) begin
                        if (cnt_full) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (frame_kind_c == SINGLE) begin
                        cand_d = frame_code_c;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (frame_kind_c == NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_down_d = 1'b0;
                        end else begin
                            state_d = RELEASE_DB;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (frame_kind_c == NONE) begin
                        if (cnt_full) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_down_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=3).
// A keypad model pulls a column low while its row is driven and a key is held.
module tb_keypad_matrix_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 3;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } pulse_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_key;
    logic [3:0] out_signal;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_key;

    logic [11:0] pressed;
    int          cyc;
    int          n_checks;
    int          n_fail;
    pulse_t      exp_q[$];
    pulse_t      got_e;

    keypad_matrix_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_key     (in_key),
        .out_signal (out_signal),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .multi_key  (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Membrane keypad: a held key shorts its row line to its column line.
    always_comb begin
        in_key = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r * 3 + c] && !out_signal[r]) in_key[c] = 1'b0;
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int key_bit(input logic [3:0] code);
        case (code)
            4'hA:    return 9;
            4'h0:    return 10;
            4'hB:    return 11;
            default: return int'(code) - 1;
        endcase
    endfunction

    // Monitor: every key_valid pulse must match the next expected press.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got code %0h at cycle %0d, expected no pulse", key_code, cyc);
            end else begin
                got_e = exp_q.pop_front();
                check("pulse_code", 32'(key_code), 32'(got_e.code));
                check("pulse_cycle", 32'(cyc), 32'(got_e.cyc));
            end
        end
    end

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    // Called at the start of the first stable frame.
    task automatic expect_pulse(input logic [3:0] code);
        pulse_t p;
        p.code = code;
        p.cyc  = cyc + int'(DB * FRAME);
        exp_q.push_back(p);
    endtask

    task automatic press_accept(input logic [3:0] code);
        pressed = '0;
        pressed[key_bit(code)] = 1'b1;
        expect_pulse(code);
        frames(DB + 1);
        check("down_after_press", 32'(key_down), 32'd1);
        check("code_after_press", 32'(key_code), 32'(code));
    endtask

    task automatic release_all(input logic [3:0] code_hold);
        pressed = '0;
        frames(DB - 1);
        check("down_before_release_accept", 32'(key_down), 32'd1);
        frames(1);
        check("down_after_release", 32'(key_down), 32'd0);
        check("code_held_after_release", 32'(key_code), 32'(code_hold));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pressed  = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_out_signal", 32'(out_signal), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h F);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_down", 32'(key_down), 32'd0);
        check("rst_multi_key", 32'(multi_key), 32'd0);

        // '7' held, then reset asserted in the middle of the row-2 slot.
        press_accept(4'h7);
        repeat (9) @(negedge clk);
        check("row2_driven", 32'(out_signal), 32'hB);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_signal", 32'(out_signal), 32'h E);
        check("async_rst_key_code", 32'(key_code), 32'h F);
        check("async_rst_key_down", 32'(key_down), 32'd0);
        check("async_rst_key_valid", 32'(key_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_pulse(4'h7);
        frames(DB + 1);
        check("post_rst_down", 32'(key_down), 32'd1);
        check("post_rst_code", 32'(key_code), 32'h7);
        release_all(4'h7);

        // '5' held for 20 frames: one pulse only.
        pressed = '0;
        pressed[key_bit(4'h5)] = 1'b1;
        expect_pulse(4'h5);
        frames(20);
        check("hold5_down", 32'(key_down), 32'd1);
        check("hold5_code", 32'(key_code), 32'h5);
        release_all(4'h5);

        // '8' bouncing on alternate frames, then stable.
        for (int i = 0; i < 5; i++) begin
            pressed = '0;
            if (i % 2 == 0) pressed[key_bit(4'h8)] = 1'b1;
            if (i == 4) expect_pulse(4'h8);
            frames(1);
        end
        frames(DB);
        check("bounce8_down", 32'(key_down), 32'd1);
        check("bounce8_code", 32'(key_code), 32'h8);
        release_all(4'h8);

        press_accept(4'hA);
        release_all(4'hA);
        press_accept(4'hB);
        release_all(4'hB);
        press_accept(4'h0);
        release_all(4'h0);

        // '1' and '9' together, then '9' released.
        pressed = '0;
        pressed[key_bit(4'h1)] = 1'b1;
        pressed[key_bit(4'h9)] = 1'b1;
        frames(1);
        check("multi_set", 32'(multi_key), 32'd1);
        frames(DB);
        check("multi_no_down", 32'(key_down), 32'd0);
        check("multi_still_set", 32'(multi_key), 32'd1);
        pressed[key_bit(4'h9)] = 1'b0;
        expect_pulse(4'h1);
        frames(1);
        check("multi_cleared", 32'(multi_key), 32'd0);
        frames(DB);
        check("after_multi_down", 32'(key_down), 32'd1);
        check("after_multi_code", 32'(key_code), 32'h1);
        release_all(4'h1);

        // No rollover: '2' held, '3' added, '2' released.
        press_accept(4'h2);
        pressed[key_bit(4'h3)] = 1'b1;
        frames(2);
        check("rollover_multi", 32'(multi_key), 32'd1);
        check("rollover_down", 32'(key_down), 32'd1);
        pressed[key_bit(4'h2)] = 1'b0;
        frames(DB);
        check("rollover_code", 32'(key_code), 32'h2);
        check("rollover_single", 32'(multi_key), 32'd0);
        pressed = '0;
        frames(1);
        check("short_release_down", 32'(key_down), 32'd1);
        pressed[key_bit(4'h3)] = 1'b1;
        frames(DB + 1);
        check("repress_down", 32'(key_down), 32'd1);
        check("repress_code", 32'(key_code), 32'h2);
        release_all(4'h2);
        press_accept(4'h3);
        release_all(4'h3);

        frames(1);
        check("pulses_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Upstream input stage for the keyboard adder.
- Drives the four rows of a 4x3 membrane keypad one at a time and samples the three columns.
- Debounces whole scan frames and emits one single-cycle key_valid pulse per physical press, with a held 4-bit key code.
- Its key_code/key_valid pair feeds the adder's operand registers directly; the adder needs no divided clock for key capture.

Parameters:
- SCAN_DIV, 1000, clk cycles each row is driven before its columns are sampled; must be >= 2.
- DEBOUNCE_FRAMES, 4, consecutive identical scan frames required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  main system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_key  input  3  column inputs (EFG pins), active-low with external pull-ups.
- out_signal  output  4  row drive (ABCD pins), active-low one-hot.
- key_code  output  4  last accepted key: 0-9, * = 4'hA, # = 4'hB; 4'hF = none yet.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_down  output  1  level, high from acceptance until release is accepted.
- multi_key  output  1  level, high while the latest complete frame saw more than one key.

Behaviour:
- Reset values (async, immediate on rst_n low, also mid-scan): out_signal=4'b1110, key_code=4'hF, key_valid=0, key_down=0, multi_key=0. All counters are zero; FSM is IDLE; synchronizer flops are 3'b111.
- Input sync: in_key passes through 2 flops before use.
- Scan: row r (0..3) is driven low for SCAN_DIV cycles.
  - On the last cycle of the slot, the synchronized columns are sampled into the frame record, then the drive advances to row r+1, wrapping 3 to 0.
  - Because of the 2-flop sync, a sample reflects pins as they were 2 cycles earlier; SCAN_DIV >= 2 covers this.
  - One frame = 4*SCAN_DIV cycles.
- Key map, as row,col -> code: 0,0=1; 0,1=2; 0,2=3; 1,0=4; 1,1=5; 1,2=6; 2,0=7; 2,1=8; 2,2=9; 3,0=A; 3,1=0; 3,2=B.
- Frame result is evaluated at the end of the row-3 slot:
  - NONE: no low column in any row.
  - SINGLE(code): exactly one low column in the whole frame.
  - MULTI: two or more low columns.
  - multi_key is updated only at frame end.
- FSM (evaluated once per frame end; cnt counts matching frames):
  - IDLE: SINGLE(c) -> PRESS_DB with cand=c, cnt=1. NONE or MULTI -> stay in IDLE.
    - If DEBOUNCE_FRAMES=1, SINGLE goes straight to HELD with the pulse.
  - PRESS_DB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES -> HELD, key_code=cand, key_valid=1 for exactly one cycle, key_down=1.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: -> IDLE.
  - HELD: NONE -> RELEASE_DB with cnt=1. SINGLE of any code, or MULTI: stay (no rollover, no new pulse).
  - RELEASE_DB:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_FRAMES -> IDLE, key_down=0.
    - SINGLE or MULTI: -> HELD.
- Latency: press stable from the start of frame k gives key_valid in the cycle after the end of frame k+DEBOUNCE_FRAMES-1. key_code updates in the same cycle as key_valid.
- key_code holds its value through release; it changes only on acceptance.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_FRAMES+1). Counters never wrap past their terminal value.

Decomposition:
- Package keypad_pkg:
  - Key code constants: KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_NONE=4'hF.
  - FSM state enum: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - Frame-result enum: NONE, SINGLE, MULTI.
- One sub-module, keypad_row_scanner:
  - Contains the input synchronizer, row drive, slot counter and frame assembly.
  - Outputs frame_done, frame_kind and frame_code.
- The debounce FSM and output registers stay in the top block.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles; the bench models the keypad by pulling a column low while its row is driven):
- Assert rst_n low mid-row-2 while '7' is HELD -> same cycle: out_signal=1110, key_code=F, key_down=0; no key_valid after release of reset until a fresh 3-frame press.
- Hold '5' (row1,col1) stable for 20 frames -> exactly one key_valid, key_code=5, key_down=1, at the cycle after the end of frame 3. Release, then 3 NONE frames -> key_down=0, key_code stays 5.
- '8' pressed in alternate frames for 5 frames, then stable -> no pulse during bouncing; exactly one pulse with code 8, 3 frames after it becomes stable.
- Press '*', release, press '#', release -> two pulses, codes A then B. Press '0' -> code 0, confirming row-3 mapping.
- Hold '1' and '9' together -> multi_key=1 after the first frame; no key_valid; FSM stays IDLE; releasing '9' alone then gives a pulse with code 1 after 3 frames.
- Hold '2' (accepted), add '3', release '2' while keeping '3' -> no new pulse. Release all for 1 frame, then re-press '3' -> no pulse (back to HELD). Release for 3 frames, then press '3' -> pulse with code 3.
